mult_seq32: RTL and testbench
=============================

// Module: mult_seq32
// PURPOSE
//   Sequencing controller for the 32-bit ripple-carry adder (add32). It
//   performs a 32x32 unsigned shift-and-add multiply, producing a 64-bit
//   product, using one add32 instance over 32 iterations.
//   Sits in mult_div as the iterative multiply unit, between an
//   issue-side valid/ready source and a result-side valid/ready sink.
// PARAMETERS
//   WIDTH   32  operand width; only 32 is supported (fixed by add32)
//   CNT_W   6   iteration counter width; must hold the value WIDTH
// PORTS
//   clk        in   1   single clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   operands a/b valid
//   in_ready   out  1   controller can accept operands
//   a          in   32  multiplicand (unsigned)
//   b          in   32  multiplier (unsigned)
//   out_valid  out  1   product valid
//   out_ready  in   1   sink accepts product
//   product    out  64  a*b (unsigned)
//   busy       out  1   high in CALC state
// BEHAVIOUR
//   Reset and clocking: one clock; reset asynchronous, active-high.
//   Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0,
//     product=0, cnt=0; all internal registers cleared.
//   Registers: mcand[31:0], acc_hi[31:0], acc_lo[31:0], cnt[CNT_W-1:0].
//     product = {acc_hi, acc_lo}.
//   FSM states: IDLE, CALC, DONE.
//   IDLE
//     - in_ready=1.
//     - On in_valid&in_ready: load mcand=a, acc_hi=0, acc_lo=b, cnt=0;
//       go to CALC.
//     - a and b are sampled only at this acceptance edge.
//   CALC (in_ready=0, busy=1), one iteration per clock:
//     - add32 inputs are a=acc_hi, b=mcand, cin=0, giving {cout,sum}.
//     - If acc_lo[0]=1: {acc_hi,acc_lo} <= {cout, sum, acc_lo[31:1]}.
//     - If acc_lo[0]=0: {acc_hi,acc_lo} <= {1'b0, acc_hi, acc_lo[31:1]}.
//     - cnt <= cnt+1. At the edge where cnt==31, go to DONE.
//     - The adder cout is kept, never dropped; no overflow is possible.
//   DONE
//     - out_valid=1; product is stable while out_valid=1.
//     - On out_valid&out_ready: go to IDLE.
//     - in_ready stays 0 in this cycle: no accept in the same cycle as
//       the result handoff.
//   Latency: if operands are accepted at edge t, out_valid goes high after
//     edge t+32. Minimum issue interval is 34 cycles, with out_ready tied
//     high.
//   Boundaries
//     - in_valid during CALC or DONE is ignored; operands are not captured.
//     - out_ready low holds DONE indefinitely, with product unchanged.
//     - a=0 or b=0 still takes the full 32 iterations (no early exit).
//     - Reset mid-CALC or in DONE aborts the operation. The result is
//       lost, and the outputs return to their reset values asynchronously.
//     - The add32 carry chain must settle within one clock period. This is
//       the critical path: 32 full-adder ripple plus the mux.
// TESTING
//   1 Reset, then a=3, b=5 with out_ready=1 -> out_valid after 32 cycles,
//     product=64'h0F.
//   2 a=32'hFFFFFFFF, b=32'hFFFFFFFF -> product=64'hFFFFFFFE_00000001
//     (exercises cout capture).
//   3 a=32'h12345678, b=0 and a=0, b=32'hDEADBEEF -> product=0, each after
//     the full 32-cycle latency.
//   4 Hold out_ready=0 for 10 cycles in DONE -> out_valid and product hold
//     stable, in_ready=0; after out_ready=1, IDLE next cycle.
//   5 Pulse in_valid with new operands during CALC -> ignored; result
//     matches the first operands.
//   6 Assert rst at iteration 15 -> out_valid=0, product=0, in_ready=1
//     immediately; a new a=7, b=6 then yields product=42.

Source files
------------

// File: rtl/mult_seq32.sv
// Iterative 32x32 unsigned shift-and-add multiplier built around a single
// ripple-carry add32; one partial-product step per clock, 64-bit result.
module mult_seq32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] acc_hi_reg;
  logic [WIDTH-1:0] acc_lo_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             load;
  logic             step;
  logic             last_iter;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // No new operand accept in the handoff cycle; IDLE comes first.
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  add32 u_add32 (
    .a    (acc_hi_reg),
    .b    (mcand_reg),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Accumulator shifts right each step; the adder carry lands in the top
  // bit so the full 64-bit product is retained without overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg  <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      cnt_reg    <= '0;
    end else if (load) begin
      mcand_reg  <= a;
      acc_hi_reg <= '0;
      acc_lo_reg <= b;
      cnt_reg    <= '0;
    end else if (step) begin
      if (acc_lo_reg[0]) begin
        {acc_hi_reg, acc_lo_reg} <= {add_cout, add_sum, acc_lo_reg[WIDTH-1:1]};
      end else begin
        {acc_hi_reg, acc_lo_reg} <= {1'b0, acc_hi_reg, acc_lo_reg[WIDTH-1:1]};
      end
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign product = {acc_hi_reg, acc_lo_reg};

endmodule

// 32-bit ripple-carry adder; the carry chain is the multiplier's critical path.
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_fa
      logic p;
      assign p             = a[gi] ^ b[gi];
      assign sum[gi]       = p ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & p);
    end
  endgenerate

  assign cout = carry[32];

endmodule

// File: tb/tb_mult_seq32.sv
// Directed-vector bench for mult_seq32: latency, handshake holds, ignored
// issue during CALC, and asynchronous abort.
module tb_mult_seq32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int total;
  int bad;

  mult_seq32 #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Issue one multiply and follow it through to handoff.
  // hold: cycles to keep out_ready low in DONE; inject: pulse in_valid mid-CALC.
  task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [63:0] exp, input int hold, input bit inject);
    int cycles;
    out_ready = (hold == 0);
    a        = op_a;
    b        = op_b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    check({tag, "_inrdy_calc"}, {63'd0, in_ready}, 64'd0);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      if (inject && cycles == 5) begin
        a        = 32'hAAAA5555;
        b        = 32'h0000FFFF;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, 64'(cycles), 64'd32);
    check({tag, "_prod"}, product, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_vld"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_hold_prod"}, product, exp);
      check({tag, "_hold_inrdy"}, {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_vld_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inrdy", {63'd0, in_ready}, 64'd1);
    check("rst_ovld", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_prod", product, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("m3x5", 32'd3, 32'd5, 64'h0F, 0, 1'b0);
    run_op("mffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0, 1'b0);
    run_op("mbzero", 32'h12345678, 32'd0, 64'd0, 0, 1'b0);
    run_op("mazero", 32'd0, 32'hDEADBEEF, 64'd0, 0, 1'b0);
    run_op("m2p16", 32'h00010000, 32'h00010000, 64'h1_0000_0000, 0, 1'b0);
    run_op("mhold", 32'h80000000, 32'd2, 64'h1_0000_0000, 10, 1'b0);
    run_op("minject", 32'd100, 32'd7, 64'd700, 0, 1'b1);

    // Abort mid-CALC: accept, run 15 iterations, then assert reset between edges.
    a        = 32'h0000FFFF;
    b        = 32'h0000FFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("abort_busy_pre", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("abort_ovld", {63'd0, out_valid}, 64'd0);
    check("abort_prod", product, 64'd0);
    check("abort_inrdy", {63'd0, in_ready}, 64'd1);
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("m7x6", 32'd7, 32'd6, 64'd42, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
